// File: rtl/maxpool_window_ctrl_if.sv
// Stream bundle for the max-pool sequencer: convolution results in, pooled values out.
// Signal names are relative to the sequencer (i_* into it, o_* out of it).
interface maxpool_window_ctrl_if #(
   parameter int DATA_W  = 48,
   parameter int COORD_W = 2
);
   logic                      i_valid;
   logic signed [DATA_W-1:0]  i_data;
   logic                      o_valid;
   logic signed [DATA_W-1:0]  o_data;
   logic [COORD_W-1:0]        o_out_col;
   logic [COORD_W-1:0]        o_out_row;
   logic                      o_frame_done;

   modport master (
      output i_valid, i_data,
      input  o_valid, o_data, o_out_col, o_out_row, o_frame_done
   );

   modport slave (
      input  i_valid, i_data,
      output o_valid, o_data, o_out_col, o_out_row, o_frame_done
   );
endinterface

// File: rtl/maxpool_window_ctrl.sv
// Streaming non-overlapping 2-D max-pool: tracks window position in a raster stream and
// keeps per-output-column partial maxima, emitting one value per completed window.
module maxpool_window_ctrl #(
   parameter int FM_SIZE   = 8,
   parameter int POOL_SIZE = 2,
   parameter int DATA_W    = 48,
   localparam int N_OUT    = FM_SIZE / POOL_SIZE,
   localparam int OC_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   localparam int K_W      = $clog2(POOL_SIZE)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   maxpool_window_ctrl_if.slave  bus
);

   localparam logic [K_W-1:0]  K_LAST  = K_W'(POOL_SIZE - 1);
   localparam logic [OC_W-1:0] OC_LAST = OC_W'(N_OUT - 1);

   logic [K_W-1:0]  kc, kr;
   logic [OC_W-1:0] oc, orow;

   logic signed [DATA_W-1:0] partial [N_OUT];
   logic signed [DATA_W-1:0] cur, mx;
   logic accept, first_elem, last_elem, last_window;

   assign accept      = bus.i_valid & ~i_clear;
   assign first_elem  = (kr == '0) && (kc == '0);
   assign last_elem   = (kr == K_LAST) && (kc == K_LAST);
   assign last_window = (oc == OC_LAST) && (orow == OC_LAST);
   assign cur         = partial[oc];
   // Ties keep the stored value; both are equal so the choice is invisible.
   assign mx          = (bus.i_data > cur) ? bus.i_data : cur;

   // Line buffer is reloaded by each window's first element, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         partial[oc] <= first_elem ? bus.i_data : mx;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         kc   <= '0;
         kr   <= '0;
         oc   <= '0;
         orow <= '0;
      end else if (i_clear) begin
         kc   <= '0;
         kr   <= '0;
         oc   <= '0;
         orow <= '0;
      end else if (bus.i_valid) begin
         if (kc == K_LAST) begin
            kc <= '0;
            if (oc == OC_LAST) begin
               oc <= '0;
               if (kr == K_LAST) begin
                  kr   <= '0;
                  orow <= (orow == OC_LAST) ? '0 : orow + 1'b1;
               end else begin
                  kr <= kr + 1'b1;
               end
            end else begin
               oc <= oc + 1'b1;
            end
         end else begin
            kc <= kc + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_valid      <= 1'b0;
         bus.o_frame_done <= 1'b0;
         bus.o_data       <= '0;
         bus.o_out_col    <= '0;
         bus.o_out_row    <= '0;
      end else begin
         bus.o_valid      <= accept & last_elem;
         bus.o_frame_done <= accept & last_elem & last_window;
         if (accept && last_elem) begin
            bus.o_data    <= mx;
            bus.o_out_col <= oc;
            bus.o_out_row <= orow;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Scoreboard bench for maxpool_window_ctrl on a 4x4 map with 2x2 windows.
module tb_maxpool_window_ctrl;
   localparam int FM   = 4;
   localparam int PS   = 2;
   localparam int DW   = 48;
   localparam int CW   = 1;

   typedef struct {
      logic signed [DW-1:0] d;
      int                   col;
      int                   row;
      bit                   fd;
      int                   cyc;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst_n;
   logic i_clear;

   maxpool_window_ctrl_if #(.DATA_W(DW), .COORD_W(CW)) bus ();

   maxpool_window_ctrl #(.FM_SIZE(FM), .POOL_SIZE(PS), .DATA_W(DW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .bus     (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fd_seen = 0;
   int fd_exp  = 0;
   exp_t sb[$];
   exp_t e;

   logic signed [DW-1:0] model_buf [FM*FM];
   int pos = 0;

   always @(posedge i_clk) cyc++;

   task automatic chk(input string tag, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Drive one sample; the reference model stores the whole frame and computes
   // each window maximum directly from the four raster positions.
   task automatic send(input logic signed [DW-1:0] v);
      int r, c;
      exp_t x;
      @(posedge i_clk); #1;
      bus.i_valid = 1'b1;
      bus.i_data  = v;
      model_buf[pos] = v;
      r = pos / FM;
      c = pos % FM;
      if ((r % PS == PS-1) && (c % PS == PS-1)) begin
         x.d = smax(smax(model_buf[(r-1)*FM + c-1], model_buf[(r-1)*FM + c]),
                    smax(model_buf[r*FM + c-1],     model_buf[r*FM + c]));
         x.col = c / PS;
         x.row = r / PS;
         x.fd  = (pos == FM*FM-1);
         x.cyc = cyc + 1;
         if (x.fd) fd_exp++;
         sb.push_back(x);
      end
      pos = (pos + 1) % (FM*FM);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk); #1;
         bus.i_valid = 1'b0;
      end
   endtask

   task automatic send_frame(input logic signed [DW-1:0] f [FM*FM], input int gap);
      for (int i = 0; i < FM*FM; i++) begin
         send(f[i]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, longint'(bus.o_valid), 0);
      chk({tag, "_data"},  bus.o_data, 0);
      chk({tag, "_col"},   longint'(bus.o_out_col), 0);
      chk({tag, "_row"},   longint'(bus.o_out_row), 0);
      chk({tag, "_fdone"}, longint'(bus.o_frame_done), 0);
   endtask

   always @(negedge i_clk) begin
      if (i_rst_n === 1'b1) begin
         if (bus.o_frame_done) fd_seen++;
         if (bus.o_frame_done && !bus.o_valid) chk("fdone_alone", 1, 0);
         if (bus.o_valid) begin
            if (sb.size() == 0) begin
               chk("extra_pulse", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("data",  bus.o_data, e.d);
               chk("col",   longint'(bus.o_out_col), e.col);
               chk("row",   longint'(bus.o_out_row), e.row);
               chk("fdone", longint'(bus.o_frame_done), longint'(e.fd));
               chk("latency", cyc, e.cyc);
            end
         end
      end
   end

   logic signed [DW-1:0] fr [FM*FM];
   logic [63:0] rnd;

   initial begin
      i_rst_n     = 1'b0;
      i_clear     = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      #3;
      chk_outputs_zero("reset");
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;

      // ascending frame
      for (int i = 0; i < FM*FM; i++) fr[i] = DW'(i + 1);
      send_frame(fr, 0);

      // negated frame
      for (int i = 0; i < FM*FM; i++) fr[i] = -DW'(i + 1);
      send_frame(fr, 0);

      // ascending with 3-cycle gaps
      for (int i = 0; i < FM*FM; i++) fr[i] = DW'(i + 1);
      send_frame(fr, 3);

      // back-to-back ascending then descending
      send_frame(fr, 0);
      for (int i = 0; i < FM*FM; i++) fr[i] = DW'(FM*FM - i);
      send_frame(fr, 0);
      idle(2);

      // partial frame abandoned by i_clear (sample on the clear cycle is dropped)
      for (int i = 0; i < 5; i++) send(DW'(100 + i));
      @(posedge i_clk); #1;
      bus.i_valid = 1'b1;
      bus.i_data  = DW'(99);
      i_clear     = 1'b1;
      pos = 0;
      @(posedge i_clk); #1;
      i_clear     = 1'b0;
      bus.i_valid = 1'b0;
      #1;
      chk("clear_no_valid", longint'(bus.o_valid), 0);
      for (int i = 0; i < FM*FM; i++) fr[i] = DW'(i + 1);
      send_frame(fr, 0);
      idle(2);

      // partial frame abandoned by a one-cycle reset
      for (int i = 0; i < 5; i++) send(DW'(200 + i));
      @(posedge i_clk); #1;
      bus.i_valid = 1'b1;
      bus.i_data  = DW'(77);
      i_rst_n     = 1'b0;
      pos = 0;
      #1;
      chk_outputs_zero("midreset");
      @(posedge i_clk); #1;
      i_rst_n     = 1'b1;
      bus.i_valid = 1'b0;
      send_frame(fr, 0);
      idle(2);

      // corner values in window (0,0), equal fives in window (0,1), random elsewhere
      for (int i = 0; i < FM*FM; i++) begin
         rnd   = {$urandom(), $urandom()};
         fr[i] = rnd[DW-1:0];
      end
      fr[0] = 48'sh8000_0000_0000;
      fr[1] = 48'sh7FFF_FFFF_FFFF;
      fr[4] = '0;
      fr[5] = -48'sd1;
      fr[2] = 48'sd5;
      fr[3] = 48'sd5;
      fr[6] = 48'sd5;
      fr[7] = 48'sd5;
      send_frame(fr, 0);
      idle(1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge i_clk);
      idle(2);
      chk("drain", sb.size(), 0);
      chk("fdone_count", fd_seen, fd_exp);
      chk("last_data_hold", bus.o_data, e.d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule

// File: doc/maxpool_window_ctrl.md
# maxpool_window_ctrl

Streaming 2-D max-pool sequencer that sits between the convolution engine's accumulator output and the next layer's input buffer. It consumes one signed 48-bit convolution result per valid cycle, in raster order over an FM_SIZE×FM_SIZE output map. It tracks the position of each result inside non-overlapping POOL_SIZE×POOL_SIZE windows and holds per-column partial maxima in a line buffer. It emits one pooled value per completed window, replacing the per-window clean/enable sequencing that the single-register max-pool stage needs.

## Interface
- FM_SIZE, 8, width/height of incoming convolution map; must be a multiple of POOL_SIZE.
- POOL_SIZE, 2, pooling window edge; stride equals POOL_SIZE; legal range 2..FM_SIZE.
- DATA_W, 48, signed data width.
- i_clk  input  1  sole clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_clear  input  1  synchronous frame restart; zeroes counters, drops partial window state.
- i_valid  input  1  i_data holds a convolution result this cycle.
- i_data  input  DATA_W  signed convolution result.
- o_valid  output  1  one-cycle pulse; o_data holds a pooled value.
- o_data  output  DATA_W  signed window maximum; holds last value between pulses.
- o_out_col  output  clog2(FM_SIZE/POOL_SIZE)  pooled-map column of o_data.
- o_out_row  output  clog2(FM_SIZE/POOL_SIZE)  pooled-map row of o_data.
- o_frame_done  output  1  one-cycle pulse coincident with the last o_valid of a frame.

## Operation
- Counters: kc (0..POOL_SIZE-1, column within window), oc (0..FM_SIZE/POOL_SIZE-1, output column), kr (row within window), orow (output row). Counters advance only on accepted i_valid.
- Column advance: kc increments; at POOL_SIZE-1 it wraps to 0 and oc increments. At end of the input row, oc wraps to 0 and kr increments. kr wraps at POOL_SIZE-1, which increments orow. orow wraps at end of frame; the next frame starts without further action.
- Line buffer: partial[0..FM_SIZE/POOL_SIZE-1], DATA_W each, signed.
- Per accepted sample:
  - First element of a window (kr==0 and kc==0): partial[oc] ← i_data (load; previous contents ignored).
  - Other elements: partial[oc] ← max(partial[oc], i_data).
  - Last element (kr==POOL_SIZE-1 and kc==POOL_SIZE-1): o_data ← max(partial[oc], i_data), o_out_col ← oc, o_out_row ← orow, o_valid ← 1.
- Comparison is signed, full DATA_W; no truncation or saturation. On ties the stored value is kept (values are identical).
- o_frame_done asserts with the o_valid for oc and orow both at their maxima.
- i_clear has priority over i_valid in the same cycle: the sample is dropped, counters go to 0, and o_valid/o_frame_done are 0 next cycle. o_data keeps its value. Line-buffer contents become don't-care; they are reloaded by the next first element.
- Gaps in i_valid of any length are legal. State holds and no output is produced.

## Timing
- Reset (i_rst_n low, asynchronous): all counters 0, o_valid 0, o_frame_done 0, o_data 0, o_out_col 0, o_out_row 0. Line buffer need not be reset.
- Reset mid-frame discards the partial frame. The first valid after release is treated as pixel (0,0).
- Latency: o_valid rises on the clock edge that samples the window's last i_valid, so it is visible 1 cycle after that input is presented.
- Throughput: one input per cycle sustained. Outputs never overlap, since at most one window completes per input.
- No backpressure: downstream must accept every o_valid pulse.

## Test plan
- FM_SIZE=4, POOL_SIZE=2, inputs 1..16 back-to-back in raster order:
  - o_valid pulses carry 6 (0,0), 8 (0,1), 14 (1,0), 16 (1,1).
  - o_frame_done is set with 16.
  - Each pulse occurs 1 cycle after inputs 6, 8, 14, 16 respectively.
- Same frame negated (-1..-16): outputs -1, -3, -9, -11. This confirms signed compare and load-on-first rather than max-with-zero.
- Frame 1..16 with i_valid deasserted for 3 cycles after every sample: same four values and coordinates, with no extra or missing pulses.
- Two frames back-to-back (1..16, then 16..1): second frame yields 16, 14, 8, 6. This proves the line buffer reloads and the counters wrap cleanly.
- Drive 5 samples, pulse i_clear (with i_valid=1 on that cycle), then send 1..16: only the four outputs 6, 8, 14, 16 appear. Repeat the sequence with i_rst_n low for 1 cycle in place of i_clear: same result, and all outputs are 0 during reset.
- Corner values: window {-2^47, 2^47-1, 0, -1} yields 2^47-1; window of four equal values 5 yields 5.
